// File: rtl/unified_mem_model_pkg.sv
// Shared constants, FSM state type and byte-lane mapping helper for the unified memory model.
package mem_pkg;

    localparam logic [31:0] FILL_WORD = 32'hDEADBEEF;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_e;

    // Byte position within the bus word that carries storage lane k.
    function automatic int lane_sel(input int k, input bit little_end, input int lanes);
        return little_end ? k : (lanes - 1 - k);
    endfunction

endpackage

// File: rtl/unified_mem_model_if.sv
// Request/response bus between the memory arbiter (master) and the memory model (slave).
interface unified_mem_model_if #(
    parameter int DATA_W = 32
);
    localparam int LANES = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic [31:0]       ram_addr;
    logic [LANES-1:0]  ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              rvalid;
    logic              err;

    modport master (
        output req_valid, ram_addr, ram_we, ram_wdata,
        input  req_ready, ram_rdata, rvalid, err
    );

    modport slave (
        input  req_valid, ram_addr, ram_we, ram_wdata,
        output req_ready, ram_rdata, rvalid, err
    );

endinterface

// File: rtl/unified_mem_model_rd_pipe.sv
// Read-response delay line carrying {valid, err, data}; data stages only load on valid so
// the last response is held between strobes.
module mem_rd_pipe #(
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic              in_err_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic              out_err_o,
    output logic [DATA_W-1:0] out_data_o
);

    if (READ_LAT == 0) begin : g_comb
        logic [DATA_W-1:0] hold_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                hold_q <= '0;
            end else if (in_valid_i) begin
                hold_q <= in_data_i;
            end
        end

        assign out_valid_o = in_valid_i;
        assign out_err_o   = in_valid_i & in_err_i;
        assign out_data_o  = in_valid_i ? in_data_i : hold_q;
    end else begin : g_pipe
        logic [READ_LAT-1:0] vld_pipe_q;
        logic [READ_LAT-1:0] err_pipe_q;
        logic [DATA_W-1:0]   data_pipe_q [READ_LAT];

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_pipe_q <= '0;
                err_pipe_q <= '0;
                for (int i = 0; i < READ_LAT; i++) data_pipe_q[i] <= '0;
            end else begin
                vld_pipe_q[0] <= in_valid_i;
                err_pipe_q[0] <= in_valid_i & in_err_i;
                if (in_valid_i) data_pipe_q[0] <= in_data_i;
                for (int i = 1; i < READ_LAT; i++) begin
                    vld_pipe_q[i] <= vld_pipe_q[i-1];
                    err_pipe_q[i] <= err_pipe_q[i-1];
                    if (vld_pipe_q[i-1]) data_pipe_q[i] <= data_pipe_q[i-1];
                end
            end
        end

        assign out_valid_o = vld_pipe_q[READ_LAT-1];
        assign out_err_o   = err_pipe_q[READ_LAT-1];
        assign out_data_o  = data_pipe_q[READ_LAT-1];
    end

endmodule

// File: rtl/unified_mem_model.sv
// Unified instruction/data RAM: byte-lane writes, selectable endianness, pipelined reads,
// optional zero-fill after reset and illegal-access reporting.
module unified_mem_model
    import mem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LAT     = 1,
    parameter int LITTLE_END   = 1,
    parameter int CLEAR_ON_RST = 1,
    parameter     INIT_FILE    = ""
) (
    input  logic                clk,
    input  logic                rst,
    unified_mem_model_if.slave  bus,
    output logic                init_done
);

    localparam int          LANES = DATA_W / 8;
    localparam int          LB    = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BYTES = 33'(DEPTH_WORDS * LANES);
    localparam bit          LE    = (LITTLE_END != 0);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    state_e            state_q;
    logic [AW-1:0]     clr_idx_q;
    logic              req_ready_q;
    logic              init_done_q;
    logic              werr_q;

    logic              accept;
    logic              is_write;
    logic              misalign;
    logic              oor;
    logic              illegal;
    logic [AW-1:0]     widx;
    logic [DATA_W-1:0] fill;
    logic [DATA_W-1:0] rd_word;

    for (genvar i = 0; i < DATA_W; i++) begin : g_fill
        assign fill[i] = FILL_WORD[i % 32];
    end

    assign accept   = bus.req_valid & req_ready_q;
    assign is_write = |bus.ram_we;
    assign misalign = (bus.ram_addr & 32'(LANES - 1)) != 32'd0;
    assign oor      = {1'b0, bus.ram_addr} >= BYTES;
    assign illegal  = misalign | oor;
    assign widx     = bus.ram_addr[AW+LB-1:LB];

    // Clear has priority; the port is not ready during S_CLEAR so the two never compete.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_CLEAR) begin
            mem[clr_idx_q] <= '0;
        end else if (!rst && accept && is_write && !illegal) begin
            for (int k = 0; k < LANES; k++) begin
                if (bus.ram_we[k]) mem[widx][8*k +: 8] <= bus.ram_wdata[8*lane_sel(k, LE, LANES) +: 8];
            end
        end
    end

    always_comb begin
        rd_word = fill;
        if (!illegal) begin
            for (int k = 0; k < LANES; k++) begin
                rd_word[8*lane_sel(k, LE, LANES) +: 8] = mem[widx][8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_RUN;
            clr_idx_q   <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            werr_q      <= 1'b0;
        end else begin
            werr_q <= accept & is_write & illegal;
            case (state_q)
                S_CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
                        state_q     <= S_RUN;
                        req_ready_q <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    req_ready_q <= 1'b1;
                    init_done_q <= 1'b1;
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    logic pipe_err;

    mem_rd_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (accept & ~is_write & ~rst),
        .in_err_i    (illegal),
        .in_data_i   (rd_word),
        .out_valid_o (bus.rvalid),
        .out_err_o   (pipe_err),
        .out_data_o  (bus.ram_rdata)
    );

    assign bus.err       = pipe_err | werr_q;
    assign bus.req_ready = req_ready_q;
    assign init_done     = init_done_q;

endmodule
